// File: rtl/wbdma_copy.sv
// rtl/wbdma_copy.sv - Wishbone memory-to-memory word copy engine with CSR page
//
// Optional feature: define WBDMA_COPY_TIMEOUT_EN to enable the 8-bit ack watchdog.
//
// Ports:
//   sys_clk, sys_rst_n      clock (rising edge), asynchronous active-low reset
//   csr_a/csr_we/csr_di     CSR slave write/address; csr_do registered read data
//                           (0 when the page in csr_a[13:10] is not ours)
//   wb_*                    Wishbone classic master (sel=4'hf, cti=3'b000)
//   irq                     one-cycle pulse on completion or watchdog error

module wbdma_copy #(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  input  logic        wb_ack_i,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_GAP_W = 3'd2,
    S_WR    = 3'd3,
    S_GAP_R = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  logic [31:0] csr_do_q, csr_do_d;

  logic csr_sel, csr_wr, start, abort, busy, stb, wdog_hit;

  // Word-aligned CSR decode only looks at bits [1:0]; the rest of the in-page
  // offset is don't-care.
  logic unused_csr_bits;
  assign unused_csr_bits = ^csr_a[9:2];

  assign csr_sel = (csr_a[13:10] == csr_addr);
  assign csr_wr  = csr_sel && csr_we;
  assign start   = csr_wr && (csr_a[1:0] == 2'd3) && csr_di[0];
  assign abort   = csr_wr && (csr_a[1:0] == 2'd3) && csr_di[1];
  assign busy    = (state_q != S_IDLE);
  assign stb     = (state_q == S_RD) || (state_q == S_WR);

  // Bus outputs decode straight from the state register so that an
  // asynchronous reset drops the cycle without waiting for a clock edge.
  assign wb_cyc_o = busy;
  assign wb_stb_o = stb;
  assign wb_we_o  = (state_q == S_WR);
  assign wb_adr_o = (state_q == S_WR) ? dst_q : ((state_q == S_RD) ? src_q : 32'h0);
  assign wb_dat_o = data_q;
  assign wb_sel_o = 4'hf;
  assign wb_cti_o = 3'b000;
  assign irq      = irq_q;
  assign csr_do   = csr_do_q;

`ifdef WBDMA_COPY_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  // Counts strobe cycles without ack; fires on the 255th such cycle.
  assign wdog_hit = stb && !wb_ack_i && (wdog_q == 8'd254);

  always_comb begin
    wdog_d = wdog_q;
    if (!stb || wb_ack_i) wdog_d = 8'd0;
    else                  wdog_d = wdog_q + 8'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) wdog_q <= 8'd0;
    else            wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    irq_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (csr_wr) begin
        case (csr_a[1:0])
          2'd0:    src_d = {csr_di[31:2], 2'b00};
          2'd1:    dst_d = {csr_di[31:2], 2'b00};
          2'd2:    len_d = csr_di[15:0];
          default: ;
        endcase
      end
      // Abort in the same write as start suppresses the start.
      if (start && !abort) begin
        err_d = 1'b0;
        if (len_q != 16'd0) begin
          done_d  = 1'b0;
          state_d = S_RD;
        end else begin
          done_d = 1'b1;
          irq_d  = 1'b1;
        end
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_RD: begin
          if (wb_ack_i) begin
            data_d  = wb_dat_i;
            state_d = S_GAP_W;
          end else if (wdog_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            irq_d   = 1'b1;
          end
        end
        S_GAP_W: state_d = S_WR;
        S_WR: begin
          if (wb_ack_i) begin
            src_d = src_q + 32'd4;
            dst_d = dst_q + 32'd4;
            len_d = len_q - 16'd1;
            if (len_q == 16'd1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end else begin
              state_d = S_GAP_R;
            end
          end else if (wdog_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            irq_d   = 1'b1;
          end
        end
        S_GAP_R: state_d = S_RD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_do_d = 32'h0;
    if (csr_sel) begin
      case (csr_a[1:0])
        2'd0:    csr_do_d = src_q;
        2'd1:    csr_do_d = dst_q;
        2'd2:    csr_do_d = {16'h0, len_q};
        default: csr_do_d = {29'h0, err_q, done_q, busy};
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      len_q    <= 16'h0;
      data_q   <= 32'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      csr_do_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
      csr_do_q <= csr_do_d;
    end
  end

endmodule

// File: tb/tb_wbdma_copy.sv
// tb/tb_wbdma_copy.sv - directed self-checking bench for wbdma_copy

module tb_wbdma_copy;

  localparam logic [13:0] A_SRC  = 14'h0000;
  localparam logic [13:0] A_DST  = 14'h0001;
  localparam logic [13:0] A_LEN  = 14'h0002;
  localparam logic [13:0] A_CTRL = 14'h0003;
  localparam logic [13:0] A_P1   = 14'h0400;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic [2:0]  wb_cti_o;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic        slave_en = 1'b0;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  int          irq_cnt = 0;
  int          stb_cycles = 0;
  logic        cyc_seen = 1'b0;

  always #5 sys_clk = ~sys_clk;

  wbdma_copy dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .csr_a    (csr_a),
    .csr_we   (csr_we),
    .csr_di   (csr_di),
    .csr_do   (csr_do),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_cti_o (wb_cti_o),
    .wb_ack_i (wb_ack_i),
    .irq      (irq)
  );

  // Slave: acks each strobe in its first cycle; read data = 0xD0000000 ^ address.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(negedge sys_clk);
      if (slave_en && wb_stb_o === 1'b1 && !wb_ack_i) begin
        log_adr.push_back(wb_adr_o);
        log_we.push_back(wb_we_o);
        log_dat.push_back(wb_we_o ? wb_dat_o : (32'hD000_0000 ^ wb_adr_o));
        wb_dat_i = 32'hD000_0000 ^ wb_adr_o;
        wb_ack_i = 1'b1;
      end else begin
        wb_ack_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      if (irq === 1'b1) irq_cnt++;
      if (wb_cyc_o === 1'b1) cyc_seen = 1'b1;
      if (wb_stb_o === 1'b1) stb_cycles++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
    csr_di = 32'h0;
  endtask

  task automatic csr_rd(input logic [13:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    csr_a  = a;
    csr_we = 1'b0;
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic wait_status(input logic [31:0] mask, output logic [31:0] st);
    st = 32'h0;
    for (int i = 0; i < 200; i++) begin
      csr_rd(A_CTRL, st);
      if ((st & mask) != 32'h0) break;
    end
  endtask

  task automatic set_slave(input logic v);
    @(posedge sys_clk);
    #1;
    slave_en = v;
  endtask

  task automatic clear_mon();
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
    irq_cnt    = 0;
    stb_cycles = 0;
    cyc_seen   = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    sys_rst_n = 1'b0;
    csr_a     = 14'h0;
    csr_we    = 1'b0;
    csr_di    = 32'h0;
    repeat (2) @(negedge sys_clk);
    check("rst cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("rst stb", {31'h0, wb_stb_o}, 32'h0);
    check("rst we",  {31'h0, wb_we_o},  32'h0);
    check("rst adr", wb_adr_o, 32'h0);
    check("rst dat", wb_dat_o, 32'h0);
    check("rst irq", {31'h0, irq}, 32'h0);
    check("rst csr_do", csr_do, 32'h0);
    check("sel/cti", {25'h0, wb_sel_o, wb_cti_o}, {25'h0, 4'hf, 3'b000});
    sys_rst_n = 1'b1;

    csr_rd(A_SRC, r);  check("rst SRC", r, 32'h0);
    csr_rd(A_LEN, r);  check("rst LEN", r, 32'h0);
    csr_rd(A_CTRL, r); check("rst STATUS", r, 32'h0);

    // Basic 3-word copy.
    set_slave(1'b1);
    csr_wr(A_SRC, 32'h0000_0103);
    csr_rd(A_SRC, r);  check("SRC align", r, 32'h100);
    csr_rd(A_P1, r);   check("other page read", r, 32'h0);
    csr_wr(A_P1 | A_SRC, 32'h0000_0F00);
    csr_rd(A_SRC, r);  check("other page write", r, 32'h100);
    csr_wr(A_DST, 32'h0000_0200);
    csr_wr(A_LEN, 32'h0000_0003);
    clear_mon();
    csr_wr(A_CTRL, 32'h1);
    check("A cyc after start", {31'h0, wb_cyc_o}, 32'h1);
    check("A first adr", wb_adr_o, 32'h100);
    wait_status(32'h2, r);
    check("A STATUS", r, 32'h2);
    check("A n xfers", log_adr.size(), 32'd6);
    if (log_adr.size() == 6) begin
      check("A adr0", log_adr[0], 32'h100);
      check("A adr1", log_adr[1], 32'h200);
      check("A we1",  {31'h0, log_we[1]}, 32'h1);
      check("A dat1", log_dat[1], 32'hD000_0100);
      check("A adr2", log_adr[2], 32'h104);
      check("A adr3", log_adr[3], 32'h204);
      check("A dat3", log_dat[3], 32'hD000_0104);
      check("A adr5", log_adr[5], 32'h208);
      check("A dat5", log_dat[5], 32'hD000_0108);
    end
    check("A irq count", irq_cnt, 32'd1);
    check("A cyc idle", {31'h0, wb_cyc_o}, 32'h0);
    csr_rd(A_LEN, r);  check("A LEN", r, 32'h0);
    csr_rd(A_SRC, r);  check("A SRC", r, 32'h10C);
    csr_rd(A_DST, r);  check("A DST", r, 32'h20C);

    // Zero-length start.
    clear_mon();
    csr_wr(A_CTRL, 32'h1);
    check("B irq", {31'h0, irq}, 32'h1);
    csr_rd(A_CTRL, r); check("B STATUS", r, 32'h2);
    repeat (3) @(negedge sys_clk);
    check("B irq count", irq_cnt, 32'd1);
    check("B no cyc", {31'h0, cyc_seen}, 32'h0);

    // Abort after the second write ack; LEN write while busy is dropped.
    csr_wr(A_SRC, 32'h0000_0300);
    csr_wr(A_DST, 32'h0000_0200);
    csr_wr(A_LEN, 32'h0000_0004);
    clear_mon();
    csr_wr(A_CTRL, 32'h1);
    csr_wr(A_LEN, 32'h0000_0009);
    for (int i = 0; i < 100 && log_adr.size() < 4; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check("C two writes", log_adr.size(), 32'd4);
    csr_wr(A_CTRL, 32'h2);
    check("C cyc dropped", {31'h0, wb_cyc_o}, 32'h0);
    csr_rd(A_CTRL, r); check("C STATUS", r, 32'h0);
    csr_rd(A_LEN, r);  check("C LEN", r, 32'h2);
    csr_rd(A_DST, r);  check("C DST", r, 32'h208);
    csr_rd(A_SRC, r);  check("C SRC", r, 32'h308);
    check("C irq count", irq_cnt, 32'd0);
    if (log_adr.size() >= 4) check("C dat3", log_dat[3], 32'hD000_0304);

    // Start and abort together in IDLE.
    csr_wr(A_LEN, 32'h0000_0001);
    clear_mon();
    csr_wr(A_CTRL, 32'h3);
    check("D cyc", {31'h0, wb_cyc_o}, 32'h0);
    csr_rd(A_CTRL, r); check("D STATUS", r, 32'h0);
    check("D no cyc", {31'h0, cyc_seen}, 32'h0);
    check("D irq count", irq_cnt, 32'd0);

    // Source address wrap.
    csr_wr(A_SRC, 32'hFFFF_FFFC);
    csr_wr(A_DST, 32'h0000_0400);
    csr_wr(A_LEN, 32'h0000_0002);
    clear_mon();
    csr_wr(A_CTRL, 32'h1);
    wait_status(32'h2, r);
    check("E STATUS", r, 32'h2);
    check("E n xfers", log_adr.size(), 32'd4);
    if (log_adr.size() == 4) begin
      check("E adr0", log_adr[0], 32'hFFFF_FFFC);
      check("E adr2 wrap", log_adr[2], 32'h0);
      check("E dat3", log_dat[3], 32'hD000_0000);
    end
    csr_rd(A_SRC, r);  check("E SRC", r, 32'h4);

    // Slave never acks.
    set_slave(1'b0);
    csr_wr(A_LEN, 32'h0000_0001);
    clear_mon();
    csr_wr(A_CTRL, 32'h1);
`ifdef WBDMA_COPY_TIMEOUT_EN
    for (int i = 0; i < 400 && wb_cyc_o === 1'b1; i++) @(negedge sys_clk);
    check("F cyc timeout", {31'h0, wb_cyc_o}, 32'h0);
    check("F stb cycles", stb_cycles, 32'd255);
    check("F irq count", irq_cnt, 32'd1);
    csr_rd(A_CTRL, r); check("F STATUS", r, 32'h4);
`else
    repeat (300) @(negedge sys_clk);
    check("F cyc held", {31'h0, wb_cyc_o}, 32'h1);
    csr_rd(A_CTRL, r); check("F STATUS busy", r, 32'h1);
    csr_wr(A_CTRL, 32'h2);
    check("F cyc abort", {31'h0, wb_cyc_o}, 32'h0);
    check("F irq count", irq_cnt, 32'd0);
`endif

    // Reset in the middle of a write.
    set_slave(1'b1);
    csr_wr(A_SRC, 32'h0000_0500);
    csr_wr(A_DST, 32'h0000_0600);
    csr_wr(A_LEN, 32'h0000_0003);
    csr_wr(A_CTRL, 32'h1);
    for (int i = 0; i < 50 && wb_we_o !== 1'b1; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check("G in WR", {31'h0, wb_we_o}, 32'h1);
    sys_rst_n = 1'b0;
    #1;
    check("G rst cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("G rst stb", {31'h0, wb_stb_o}, 32'h0);
    check("G rst we",  {31'h0, wb_we_o},  32'h0);
    check("G rst adr", wb_adr_o, 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    csr_rd(A_SRC, r);  check("G SRC", r, 32'h0);
    csr_rd(A_DST, r);  check("G DST", r, 32'h0);
    csr_rd(A_LEN, r);  check("G LEN", r, 32'h0);
    csr_rd(A_CTRL, r); check("G STATUS", r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wbdma_copy.md
WBDMA_COPY -- requirements
Module: wbdma_copy

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0, meaning the CSR page selected when csr_a[13:10] equals csr_addr.
REQ-002 SHALL have port sys_clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports csr_a input 14, csr_we input 1, csr_di input 32, csr_do output 32: CSR slave interface.
REQ-005 SHALL have Wishbone master ports wb_adr_o output 32, wb_dat_o output 32, wb_dat_i input 32, wb_sel_o output 4, wb_we_o output 1, wb_cyc_o output 1, wb_stb_o output 1, wb_cti_o output 3, wb_ack_i input 1.
REQ-006 SHALL have port irq  output  1  one-cycle completion/error pulse.

Function
REQ-007 SHALL decode CSR words by csr_a[1:0]: 0 SRC, 1 DST, 2 LEN (bits 15:0, word count), 3 CTRL/STATUS.
REQ-008 SHALL force SRC/DST bits 1:0 to zero on write; reads return the current, advancing address.
REQ-009 SHALL return remaining word count on LEN reads.
REQ-010 SHALL define CTRL write bits: bit0 start, bit1 abort; STATUS read bits: bit0 busy, bit1 done, bit2 err, others 0.
REQ-011 SHALL register csr_do one cycle after csr_a presentation; csr_do SHALL be 0 when page not selected (OR-bus compatible).
REQ-012 SHALL drive wb_sel_o = 4'hf and wb_cti_o = 3'b000 (classic cycles) constantly.
REQ-013 SHALL implement FSM states IDLE, RD, GAP_W, WR, GAP_R.
REQ-014 IDLE: on start with LEN!=0, clear done/err, set busy, go RD; wb_cyc_o/wb_stb_o rise the cycle after the CSR write.
REQ-015 Start with LEN==0 SHALL set done and pulse irq next cycle with no bus cycle.
REQ-016 RD: wb_we_o=0, wb_adr_o=SRC; on wb_ack_i latch wb_dat_i, deassert wb_stb_o next cycle, go GAP_W.
REQ-017 GAP_W: one cycle, stb low, cyc held high, then WR.
REQ-018 WR: wb_we_o=1, wb_adr_o=DST, wb_dat_o=latched word; on wb_ack_i: SRC+=4, DST+=4, LEN-=1.
REQ-019 After WR ack, if new LEN==0 SHALL drop cyc/stb, clear busy, set done, pulse irq, go IDLE; else GAP_R (one cycle, cyc high) then RD.
REQ-020 Address increment SHALL wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-021 wb_cyc_o SHALL remain high for the entire transfer (bus held through gap cycles).
REQ-022 Start while busy SHALL be ignored; SRC/DST/LEN writes while busy SHALL be ignored.
REQ-023 Abort while busy SHALL drop cyc/stb/we next cycle, clear busy, leave done=0, err=0, no irq; registers keep current values.
REQ-024 Simultaneous start+abort in IDLE: abort wins, no transfer.
REQ-025 wb_ack_i outside an active strobe SHALL be ignored.

Reset
REQ-026 Assertion of sys_rst_n SHALL immediately force IDLE, all registers 0, csr_do=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, irq=0.
REQ-027 Reset mid-transfer SHALL terminate bus cycle asynchronously; no done/err after release.

Configuration
REQ-028 Macro WBDMA_COPY_TIMEOUT_EN defined: 8-bit watchdog counts stb-high cycles without ack; at 255 SHALL drop cyc/stb, set err, clear busy, pulse irq, go IDLE; counter clears on each ack.
REQ-029 Macro undefined: no watchdog, wait indefinitely for ack, STATUS bit2 reads 0.

Verification
REQ-030 SRC=0x100, DST=0x200, LEN=3, start, slave ack 1-cycle -> 3 reads 0x100/104/108 and 3 writes 0x200/204/208 with matching data, done=1, irq one pulse, LEN reads 0.
REQ-031 LEN=0, start -> STATUS=0x2 next cycle, irq pulse, wb_cyc_o never high.
REQ-032 LEN=4, abort after second write ack -> cyc low next cycle, STATUS=0x0, LEN reads 2, DST reads 0x208, no irq.
REQ-033 SRC=0xFFFFFFFC, LEN=2 -> second read at 0x00000000.
REQ-034 With WBDMA_COPY_TIMEOUT_EN, slave never acks -> cyc drops after 255 strobe cycles, STATUS=0x4, irq pulse; without macro cyc stays high.
REQ-035 sys_rst_n low during WR -> cyc/stb/we low same cycle, all CSRs read 0 after release.
